// File: rtl/uart_rx_core_if.sv
// -----------------------------------------------------------------------------
// uart_rx_core_if
// Receive-side output bus of the UART receive engine toward the RX FIFO.
//   rx_data          [7:0] received word, LSB-aligned, unused upper bits 0
//   rx_data_valid          one-clk push strobe for rx_data and the error flags
//   rx_frame_error         one-clk pulse with rx_data_valid: a stop bit was 0
//   rx_parity_error        one-clk pulse with rx_data_valid: parity mismatch
// Modports: master = receive engine (drives), slave = FIFO / consumer.
// -----------------------------------------------------------------------------
interface uart_rx_core_if;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_frame_error;
    logic       rx_parity_error;

    modport master (
        output rx_data,
        output rx_data_valid,
        output rx_frame_error,
        output rx_parity_error
    );

    modport slave (
        input rx_data,
        input rx_data_valid,
        input rx_frame_error,
        input rx_parity_error
    );
endinterface

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// Serial receive engine of the UART: oversamples rxd, deframes start, 5..8
// data bits (LSB first), optional even parity and one or two stop bits, and
// pushes each word with its error flags to the RX FIFO.
//
// Ports:
//   clk            system clock
//   rstn           asynchronous active-low reset
//   baud_tick      single-cycle enable, OVERSAMPLE pulses per bit time
//   rxd            asynchronous serial input, idle high
//   word_length    00=5, 01=6, 10=7, 11=8 data bits (latched at start bit)
//   parity_en      1 = even parity bit follows the data (latched at start bit)
//   two_stop_bits  1 = two stop bits expected (latched at start bit)
//   rx_if          master side of uart_rx_core_if (data, valid, error pulses)
//   rx_busy        high from validated start bit until the frame completes
//
// Build option:
//   UART_RX_MAJORITY_VOTE_EN  when defined, each bit is the 2-of-3 majority of
//                             samples at cnt = OVERSAMPLE/2-2, -1 and
//                             OVERSAMPLE/2; the decision is taken at the third.
// -----------------------------------------------------------------------------
module uart_rx_core #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  baud_tick,
    input  logic                  rxd,
    input  logic [1:0]            word_length,
    input  logic                  parity_en,
    input  logic                  two_stop_bits,
    uart_rx_core_if.master        rx_if,
    output logic                  rx_busy
);

    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_LAST   = CW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] CNT_V0     = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [CW-1:0] CNT_V1     = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_DECIDE = CW'(OVERSAMPLE / 2);
`else
    localparam logic [CW-1:0] CNT_DECIDE = CW'(OVERSAMPLE / 2 - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;
    logic [CW-1:0]          r_cnt;
    logic                   r_armed;
    logic [2:0]             r_bitidx;
    logic [7:0]             r_shift;
    logic [1:0]             r_wl;
    logic                   r_pen;
    logic                   r_two;
    logic                   r_perr;
    logic                   r_ferr;
    logic                   r_busy;

    logic w_wrap;
    logic w_samp;
    logic w_bit;
    logic w_last_bit;
    logic w_start;
    logic w_done;

    // Input synchroniser; resets to idle-high so reset never looks like a start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rxd};
        end
    end

    assign w_rxs      = r_sync[SYNC_STAGES-1];
    assign w_wrap     = baud_tick && (r_cnt == CNT_LAST);
    assign w_samp     = baud_tick && (r_cnt == CNT_DECIDE);
    assign w_last_bit = (r_bitidx == ({1'b0, r_wl} + 3'd4));

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] r_vote;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vote <= '1;
        end else if (baud_tick) begin
            if (r_cnt == CNT_V0) r_vote[0] <= w_rxs;
            if (r_cnt == CNT_V1) r_vote[1] <= w_rxs;
        end
    end

    // Third vote is the live sample at the decision tick.
    assign w_bit = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_rxs) | (r_vote[1] & w_rxs);
`else
    assign w_bit = w_rxs;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (baud_tick && r_armed && !w_rxs) begin
                    w_state_nxt = S_START;
                    w_start     = 1'b1;
                end
            end
            S_START: begin
                if (w_samp && w_bit) begin
                    w_state_nxt = S_IDLE;
                end else if (w_wrap) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_wrap && w_last_bit) begin
                    w_state_nxt = r_pen ? S_PARITY : S_STOP1;
                end
            end
            S_PARITY: begin
                if (w_wrap) w_state_nxt = S_STOP1;
            end
            S_STOP1: begin
                if (r_two) begin
                    if (w_wrap) w_state_nxt = S_STOP2;
                end else if (w_samp) begin
                    // Complete at the stop sample, not at the end of the stop bit.
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            S_STOP2: begin
                if (w_samp) begin
                    w_state_nxt = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt                 <= '0;
            r_armed               <= 1'b0;
            r_bitidx              <= '0;
            r_shift               <= '0;
            r_wl                  <= '0;
            r_pen                 <= 1'b0;
            r_two                 <= 1'b0;
            r_perr                <= 1'b0;
            r_ferr                <= 1'b0;
            r_busy                <= 1'b0;
            rx_if.rx_data         <= '0;
            rx_if.rx_data_valid   <= 1'b0;
            rx_if.rx_frame_error  <= 1'b0;
            rx_if.rx_parity_error <= 1'b0;
        end else begin
            rx_if.rx_data_valid   <= w_done;
            rx_if.rx_frame_error  <= w_done & (r_ferr | ~w_bit);
            rx_if.rx_parity_error <= w_done & r_perr;

            if (baud_tick) r_cnt <= r_cnt + 1'b1;

            // A held-low line (break / frame error) must go high before re-arming.
            if (r_state == S_IDLE && w_rxs) r_armed <= 1'b1;

            if (w_start) begin
                r_cnt    <= '0;
                r_armed  <= 1'b0;
                r_bitidx <= '0;
                r_shift  <= '0;
                r_wl     <= word_length;
                r_pen    <= parity_en;
                r_two    <= two_stop_bits;
                r_perr   <= 1'b0;
                r_ferr   <= 1'b0;
            end

            if (r_state == S_START && w_samp && !w_bit) r_busy <= 1'b1;

            if (r_state == S_DATA) begin
                if (w_samp) r_shift[r_bitidx] <= w_bit;
                if (w_wrap) r_bitidx <= r_bitidx + 3'd1;
            end

            // Unused upper bits stay 0, so the full-width XOR is the data parity.
            if (r_state == S_PARITY && w_samp && (w_bit != ^r_shift)) r_perr <= 1'b1;

            if (r_state == S_STOP1 && w_samp && !w_bit) r_ferr <= 1'b1;

            if (w_done) begin
                rx_if.rx_data <= r_shift;
                r_busy        <= 1'b0;
                r_armed       <= w_rxs;
            end
        end
    end

    assign rx_busy = r_busy;

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Directed bench for uart_rx_core: serial frames are driven on rxd, the
// expected word/flags are queued at drive time and popped when the DUT pushes.
// baud_tick runs at one pulse every 4 clocks (64 clocks per bit).
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       baud_tick;
    logic       rxd = 1'b1;
    logic [1:0] word_length = 2'b11;
    logic       parity_en = 1'b0;
    logic       two_stop_bits = 1'b0;
    logic       rx_busy;

    uart_rx_core_if rx_if ();

    uart_rx_core #(
        .OVERSAMPLE  (16),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .baud_tick     (baud_tick),
        .rxd           (rxd),
        .word_length   (word_length),
        .parity_en     (parity_en),
        .two_stop_bits (two_stop_bits),
        .rx_if         (rx_if),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;

    logic [1:0] tick_div = 2'd0;
    logic       tick_en  = 1'b1;
    always @(posedge clk) if (tick_en) tick_div <= tick_div + 2'd1;
    assign baud_tick = tick_en && (tick_div == 2'd0);

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     checks = 0;
    int     failures = 0;
    int     n_valid = 0;
    int     n_pushed = 0;
    int     busy_hits = 0;
    int     stray_err = 0;
    longint last_valid_cyc = 0;
    longint frame_start_cyc = 0;
    longint lat1 = 0;
    longint lat2 = 0;
    logic   prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rx_busy) busy_hits++;
        if (!rx_if.rx_data_valid && (rx_if.rx_frame_error || rx_if.rx_parity_error)) stray_err++;
        if (rx_if.rx_data_valid) begin
            n_valid++;
            last_valid_cyc = cyc;
            chk("valid_width", 32'(prev_valid), 0);
            chk("busy_at_valid", 32'(rx_busy), 0);
            if (sb.size() == 0) begin
                chk("unexpected_valid", n_valid, n_pushed);
            end else begin
                mon_e = sb.pop_front();
                chk("rx_data", 32'(rx_if.rx_data), 32'(mon_e.data));
                chk("frame_error", 32'(rx_if.rx_frame_error), 32'(mon_e.fe));
                chk("parity_error", 32'(rx_if.rx_parity_error), 32'(mon_e.pe));
            end
        end
        prev_valid = rx_if.rx_data_valid;
    end

    // Returns at a falling edge just before a baud_tick rising edge.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(negedge clk); while (!baud_tick);
        end
    endtask

    task automatic drive_bit(input logic v, input int n = 16);
        rxd = v;
        wait_ticks(n);
    endtask

    task automatic idle(input int nbits);
        rxd = 1'b1;
        wait_ticks(16 * nbits);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen,
                              input bit pflip, input int nstop, input bit stop_v,
                              input bit poke, input int stall_bit);
        exp_t       e;
        logic [7:0] m;
        m      = 8'hFF >> (8 - nbits);
        e.data = d & m;
        e.fe   = !stop_v;
        e.pe   = pen && pflip;
        sb.push_back(e);
        n_pushed++;
        wait_ticks(1);
        frame_start_cyc = cyc;
        drive_bit(1'b0);
        chk("busy_in_frame", 32'(rx_busy), 1);
        for (int i = 0; i < nbits; i++) begin
            if (i == stall_bit) begin
                rxd = d[i];
                wait_ticks(8);
                tick_en = 1'b0;
                repeat (60) @(negedge clk);
                chk("busy_stalled", 32'(rx_busy), 1);
                chk("no_valid_stalled", n_valid, n_pushed - 1);
                tick_en = 1'b1;
                wait_ticks(8);
            end else begin
                drive_bit(d[i]);
            end
            if (poke && i == 2) begin
                word_length   = 2'b00;
                parity_en     = 1'b0;
                two_stop_bits = 1'b1;
            end
        end
        if (pen) drive_bit((^(d & m)) ^ pflip);
        for (int s = 0; s < nstop; s++) drive_bit(stop_v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        rxd  = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_rx_data", 32'(rx_if.rx_data), 0);
        chk("rst_valid", 32'(rx_if.rx_data_valid), 0);
        chk("rst_frame_error", 32'(rx_if.rx_frame_error), 0);
        chk("rst_parity_error", 32'(rx_if.rx_parity_error), 0);
        chk("rst_busy", 32'(rx_busy), 0);
        rstn = 1'b1;
        idle(2);

        // 8N1 0x55
        word_length = 2'b11; parity_en = 1'b0; two_stop_bits = 1'b0;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, -1);
        idle(2);
        chk("hold_data", 32'(rx_if.rx_data), 32'h55);

        // 8E1 then 8E2 with 0xA3: second completes one bit time later
        word_length = 2'b11; parity_en = 1'b1; two_stop_bits = 1'b0;
        send_frame(8'hA3, 8, 1'b1, 1'b0, 1, 1'b1, 1'b0, -1);
        idle(2);
        lat1 = last_valid_cyc - frame_start_cyc;
        two_stop_bits = 1'b1;
        send_frame(8'hA3, 8, 1'b1, 1'b0, 2, 1'b1, 1'b0, -1);
        idle(2);
        lat2 = last_valid_cyc - frame_start_cyc;
        chk("stop2_delay", 32'(lat2 - lat1), 64);

        // 7E1 0x41 with flipped parity; LCR poked mid-frame
        word_length = 2'b10; parity_en = 1'b1; two_stop_bits = 1'b0;
        send_frame(8'h41, 7, 1'b1, 1'b1, 1, 1'b1, 1'b1, -1);
        idle(2);

        // 5N1 0x1F with stop 0, line low 3 more bits, then 0x0A
        word_length = 2'b00; parity_en = 1'b0; two_stop_bits = 1'b0;
        send_frame(8'h1F, 5, 1'b0, 1'b0, 1, 1'b0, 1'b0, -1);
        drive_bit(1'b0, 48);
        chk("no_frame_while_low", n_valid, 5);
        idle(2);
        send_frame(8'h0A, 5, 1'b0, 1'b0, 1, 1'b1, 1'b0, -1);
        idle(2);

        // Glitch: 3 ticks low
        word_length = 2'b11; parity_en = 1'b0; two_stop_bits = 1'b0;
        wait_ticks(1);
        busy_hits = 0;
        rxd = 1'b0;
        wait_ticks(3);
        rxd = 1'b1;
        wait_ticks(40);
        chk("glitch_busy", busy_hits, 0);
        chk("glitch_no_valid", n_valid, 6);

        // 0x3C with baud_tick stalled inside data bit 3
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, 3);
        idle(2);

        // Reset during data bit 4 of 0xFF
        wait_ticks(1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        rxd = 1'b1;
        wait_ticks(8);
        chk("busy_before_abort", 32'(rx_busy), 1);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort_rx_data", 32'(rx_if.rx_data), 0);
        chk("abort_busy", 32'(rx_busy), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        idle(3);
        chk("abort_no_valid", n_valid, 7);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0, -1);
        idle(2);

        chk("sb_empty", sb.size(), 0);
        chk("valid_count", n_valid, n_pushed);
        chk("stray_error_pulses", stray_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
